// File: rtl/systemizer_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systemizer_seq_ctrl_pkg
// Shared definitions for the systemizer sequencer:
//   - matrix geometry (L x K elements over GF(M)), memory word layout
//   - derived widths EW/DW/AW and the WAIT timer width TW
//   - sequencer state encoding and fail_code values
// -----------------------------------------------------------------------------
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package systemizer_seq_ctrl_pkg;

  localparam int L       = 8;     // matrix rows
  localparam int K       = 16;    // matrix columns
  localparam int M       = 3;     // field size
  localparam int BLOCK   = 4;     // elements per memory word
  localparam int TIMEOUT = 4096;  // WAIT cycle budget

  localparam int EW    = `CLOG2(M);
  localparam int DW    = BLOCK * EW;
  localparam int WORDS = (L * K) / BLOCK;
  localparam int AW    = `CLOG2(WORDS);
  localparam int TW    = `CLOG2(TIMEOUT) + 1;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(WORDS - 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_RD,
    ST_HOLD,
    ST_DONE,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_CORE    = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_ABORT   = 2'd3
  } fail_code_e;

endpackage

// File: rtl/systemizer_seq_ctrl_sys_out_stage.sv
// -----------------------------------------------------------------------------
// systemizer_seq_ctrl_sys_out_stage
// Result-stream output register. Captures one core read word and presents it
// with valid/ready until the consumer takes it.
//   clk, rst_n    clock, async active-low reset
//   capture_i     load data_i this cycle (first HOLD cycle)
//   flush_i       drop any pending word (abort)
//   data_i        core read data
//   ready_i       consumer ready
//   valid_o       word pending
//   data_o        pending word, stable while valid_o && !ready_i
//   fire_o        handshake completes this cycle
// -----------------------------------------------------------------------------
module systemizer_seq_ctrl_sys_out_stage
  import systemizer_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          fire_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign fire_o  = valid_q && ready_i && !flush_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (capture_i) begin
        valid_q <= 1'b1;
      end else if (fire_o) begin
        valid_q <= 1'b0;
      end
      // Only loaded on capture, so the word holds through backpressure.
      if (capture_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/systemizer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systemizer_seq_ctrl
// Job sequencer for the systemizer core: streams a matrix in, starts the core,
// bounds its run time, streams the result out, and reports done/fail.
//   clk, rst_n                 clock, async active-low reset (shared with core;
//                              release is expected synchronous to clk)
//   cmd_start / cmd_abort      job control (abort has priority everywhere)
//   in_valid/in_data/in_ready  load stream
//   out_valid/out_data/out_ready  result stream
//   busy, job_done, job_fail, fail_code  status
//   sys_*                      core handshake and memory ports
// -----------------------------------------------------------------------------
module systemizer_seq_ctrl
  import systemizer_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic          cmd_abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          job_done,
  output logic          job_fail,
  output logic [1:0]    fail_code,
  output logic          sys_start,
  input  logic          sys_done,
  input  logic          sys_success,
  input  logic          sys_fail,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [DW-1:0] sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [DW-1:0] sys_data_out
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] timer_q, timer_d;
  fail_code_e    fail_code_q, fail_code_d;

  logic wr_fire;
  logic capture;
  logic out_fire;
  logic unused_sys_fail;

  // A core failure is fully described by sys_done && !sys_success, so
  // sys_fail carries no extra information here.
  assign unused_sys_fail = sys_fail;

  // Handshake-side strobes are gated by cmd_abort so the abort cycle never
  // writes, starts, or reads the core.
  assign in_ready    = (state_q == ST_LOAD) && !cmd_abort;
  assign wr_fire     = in_valid && in_ready;
  assign sys_wr_en   = wr_fire;
  assign sys_wr_addr = wr_fire ? addr_q  : '0;
  assign sys_data_in = wr_fire ? in_data : '0;
  assign sys_start   = (state_q == ST_RUN) && !cmd_abort;
  assign sys_rd_en   = (state_q == ST_RD) && !cmd_abort;
  assign sys_rd_addr = sys_rd_en ? addr_q : '0;

  // First HOLD cycle is the only HOLD cycle with no word pending: read data
  // from the RD cycle is valid now.
  assign capture = (state_q == ST_HOLD) && !out_valid && !cmd_abort;

  assign busy      = (state_q != ST_IDLE);
  assign job_done  = (state_q == ST_DONE);
  assign job_fail  = (state_q == ST_FAIL);
  assign fail_code = fail_code_q;

  systemizer_seq_ctrl_sys_out_stage u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture),
    .flush_i   (cmd_abort),
    .data_i    (sys_data_out),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .fire_o    (out_fire)
  );

  // NOTE: every signal written here is defaulted first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    fail_code_d = fail_code_q;

    if (cmd_abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      if (state_q != ST_IDLE) begin
        fail_code_d = FAIL_ABORT;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            state_d     = ST_LOAD;
            addr_d      = '0;
            fail_code_d = FAIL_NONE;
          end
        end
        ST_LOAD: begin
          if (wr_fire) begin
            if (addr_q == LAST_ADDR) begin
              addr_d  = '0;
              state_d = ST_RUN;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // timer_d counts cycles since sys_start; the last WAIT cycle is the
          // one where it reaches TIMEOUT-1, so job_fail lands TIMEOUT cycles
          // after sys_start. A done on that cycle still wins.
          timer_d = timer_q + 1'b1;
          if (sys_done) begin
            if (sys_success) begin
              state_d = ST_RD;
            end else begin
              state_d     = ST_FAIL;
              fail_code_d = FAIL_CORE;
            end
          end else if (timer_d == TIMER_LIMIT) begin
            state_d     = ST_FAIL;
            fail_code_d = FAIL_TIMEOUT;
          end
        end
        ST_RD: begin
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_fire) begin
            if (addr_q == LAST_ADDR) begin
              addr_d  = '0;
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_RD;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_FAIL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      timer_q     <= '0;
      fail_code_q <= FAIL_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      fail_code_q <= fail_code_d;
    end
  end

endmodule

// File: doc/systemizer_seq_ctrl.md
Name: systemizer_seq_ctrl

Overview:
Sequencer that owns the systemizer's start/done handshake and its word-wide matrix memory ports. It streams a host-supplied matrix into the core, launches systemization and bounds its run time. On success it streams the result back out; on failure or timeout it reports a fail code. Sits between the chip-top I/O glue and the systemizer core; the core's rd/wr ports are driven only by this block.

Parameters:
L, 8, matrix rows
K, 16, matrix columns
M, 3, field size; element width EW = CLOG2(M) = 2
BLOCK, 4, elements per memory word; DW = BLOCK*EW = 8
WORDS, (L*K)/BLOCK = 32, words per matrix; AW = CLOG2(WORDS) = 5
TIMEOUT, 4096, maximum cycles in WAIT before abort; counter width CLOG2(TIMEOUT)+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  single-cycle pulse; begin a load/run/unload job (ignored unless IDLE)
cmd_abort  in  1  return to IDLE next cycle from any state
in_valid  in  1  load stream valid
in_data  in  DW  load stream word
in_ready  out  1  load stream ready
out_valid  out  1  result stream valid
out_data  out  DW  result stream word
out_ready  in  1  result stream ready
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse at successful completion
job_fail  out  1  one-cycle pulse at failure
fail_code  out  2  sticky: 0 none, 1 core fail, 2 timeout, 3 aborted; cleared by cmd_start
sys_start  out  1  one-cycle start pulse to core
sys_done  in  1  core done (level or pulse; sampled only in WAIT)
sys_success  in  1  core success, valid with sys_done
sys_fail  in  1  core fail, valid with sys_done
sys_wr_en  out  1  core write enable
sys_wr_addr  out  AW  core write address
sys_data_in  out  DW  core write data
sys_rd_en  out  1  core read enable
sys_rd_addr  out  AW  core read address
sys_data_out  in  DW  core read data, valid one cycle after sys_rd_en

Behaviour:
- Reset (async assert, sync deassert inside top): state IDLE, addr 0, timer 0, fail_code 0; every output 0.
- States: IDLE, LOAD, RUN, WAIT, RD, HOLD, DONE, FAIL.
- IDLE: cmd_start -> LOAD; addr<=0; fail_code<=0.
- LOAD: in_ready=1 combinationally. On in_valid&&in_ready, same cycle: sys_wr_en=1, sys_wr_addr=addr, sys_data_in=in_data; addr++. Accepting the word at addr==WORDS-1 -> RUN; addr wraps to 0. in_valid low: stall, no write.
- RUN: sys_start=1 for exactly this cycle; timer<=0 -> WAIT.
- WAIT: timer++ each cycle. sys_done with sys_success=1 -> RD (success wins if sys_fail is also high). sys_done with sys_success=0 -> FAIL, code 1. If timer reaches TIMEOUT-1 with no sys_done -> FAIL, code 2. sys_done on that same cycle takes priority over the timeout.
- RD: sys_rd_en=1, sys_rd_addr=addr -> HOLD.
- HOLD: on the first HOLD cycle, out_data<=sys_data_out (registered); out_valid=1 from the following cycle until out_ready is seen. On out_valid&&out_ready: addr==WORDS-1 -> DONE, else addr++ -> RD. out_data is stable while out_valid&&!out_ready. Throughput is at most 1 word per 3 cycles; this is accepted.
- DONE: job_done=1 for one cycle -> IDLE.
- FAIL: job_fail=1 for one cycle -> IDLE.
- cmd_abort takes priority over every transition. It forces IDLE next cycle; fail_code=3 if the block was not in IDLE; in-flight stream words are discarded. The abort cycle itself must not assert sys_wr_en or sys_start.
- cmd_start outside IDLE is ignored. Simultaneous cmd_start and cmd_abort in IDLE: abort wins; stay IDLE; fail_code unchanged.
- Async reset mid-operation: outputs drop immediately. The core is expected to be reset by the same rst_n.

Decomposition:
- Shared package: state encoding, fail_code constants, EW/DW/AW/WORDS derivations using the existing CLOG2 macro.
- One sub-module: sys_out_stage, the HOLD capture register plus valid/ready hold logic.

Test Plan:
- Full pass: load words 0x00..0x1F with no stalls; sys_done+success 10 cycles after sys_start -> 32 writes at addr 0..31, one sys_start pulse, reads 0..31 with out_data equal to the model memory, one job_done, fail_code 0.
- Backpressure: random in_valid gaps and out_ready low for 5 cycles on word 7 -> no duplicate or missing writes/reads; out_data stable while stalled.
- Core fail: sys_done=1, sys_success=0 -> job_fail pulse, fail_code=1, no sys_rd_en, busy low next cycle.
- Timeout: sys_done never asserted -> job_fail exactly TIMEOUT cycles after sys_start, fail_code=2. Repeat with sys_done on the last cycle -> success path taken.
- Abort in LOAD after 12 words, and again in HOLD -> IDLE next cycle, fail_code=3, no further sys_wr_en/sys_rd_en. A new cmd_start clears fail_code and the rerun passes.
- Reset asserted in WAIT -> all outputs 0 asynchronously; after release, cmd_start during the first cycle is accepted from IDLE.
